// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter in front of a single-port synchronous
//            memory. The requesters are a processor (p_*) and a program
//            loader (l_*). Each access takes three states: IDLE (grant),
//            ACCESS (memory cycle) and RESP (read data capture). The
//            completion ack is a one-cycle registered pulse. When both
//            requesters are eligible, the one that was not served last wins.
// Ports    :
//   clock                          single clock, rising edge
//   reset_n                        synchronous active-low reset
//   p_req/p_we/p_addr/p_wdata      processor request, access type, address, data
//   p_ack/p_rdata                  processor completion pulse and read data
//   l_req/l_we/l_addr/l_wdata      loader request, access type, address, data
//   l_ack/l_rdata                  loader completion pulse and read data
//   mem_addr/mem_wdata/mem_we      memory address, write data, write strobe
//   mem_rdata                      memory read data, one cycle after address
//   busy                           high whenever the FSM is not IDLE
//   owner                          current/last granted requester (1 = loader)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_ack,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic p_elig;
  logic l_elig;
  logic grant_any;
  logic grant_sel;

  // A requester whose ack is high this cycle still shows its old req; it is
  // masked so the stale request is not granted a second time.
  always_comb begin
    p_elig    = p_req & ~p_ack;
    l_elig    = l_req & ~l_ack;
    grant_any = p_elig | l_elig;
    // Both eligible: serve the one that was not served last. owner resets
    // to the loader so the processor wins the first contested grant.
    grant_sel = (p_elig & l_elig) ? ~owner : l_elig;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      p_ack     <= 1'b0;
      l_ack     <= 1'b0;
      p_rdata   <= '0;
      l_rdata   <= '0;
    end else begin
      // Acks are single-cycle pulses; only the RESP branch raises one.
      p_ack <= 1'b0;
      l_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state     <= ACCESS;
            owner     <= grant_sel;
            lat_we    <= grant_sel ? l_we    : p_we;
            lat_addr  <= grant_sel ? l_addr  : p_addr;
            lat_wdata <= grant_sel ? l_wdata : p_wdata;
          end
        end
        ACCESS: begin
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          // Memory output now reflects the address presented in ACCESS.
          if (owner) begin
            l_ack <= 1'b1;
            if (!lat_we) l_rdata <= mem_rdata;
          end else begin
            p_ack <= 1'b1;
            if (!lat_we) p_rdata <= mem_rdata;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_we    = (state == ACCESS) & lat_we;
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 Parameter DATA_W, default 16, memory data width in bits.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 p_req  input  1  processor request; held until p_ack is seen.
REQ-006 p_we  input  1  processor access type: 1 = write, 0 = read.
REQ-007 p_addr  input  ADDR_W  processor address.
REQ-008 p_wdata  input  DATA_W  processor write data.
REQ-009 p_ack  output  1  one-cycle completion pulse to the processor.
REQ-010 p_rdata  output  DATA_W  processor read data; valid while p_ack=1.
REQ-011 l_req, l_we, l_addr, l_wdata  inputs  1/1/ADDR_W/DATA_W  program-loader request, with the same meanings as the p_ signals.
REQ-012 l_ack  output  1 and l_rdata  output  DATA_W  loader completion pulse and read data.
REQ-013 mem_addr  output  ADDR_W  address to the single-port synchronous memory.
REQ-014 mem_wdata  output  DATA_W  write data to the memory.
REQ-015 mem_we  output  1  memory write strobe.
REQ-016 mem_rdata  input  DATA_W  memory read data; valid one cycle after the address is presented.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 owner  output  1  current or last granted requester: 0 = processor, 1 = loader.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP; transitions are IDLE->ACCESS on grant, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-020 In IDLE, an eligible request SHALL be sampled at the clock edge, and the FSM SHALL enter ACCESS on that edge.
REQ-021 A requester SHALL be ineligible in any cycle in which its own ack is high, so a stale req is never re-granted.
REQ-022 When only one requester is eligible, that requester SHALL be granted.
REQ-023 When both are eligible, the requester other than the last-served one SHALL be granted (round-robin).
REQ-024 On grant, the arbiter SHALL latch we, addr and wdata; input changes after the grant SHALL NOT affect the access.
REQ-025 In ACCESS, mem_addr and mem_wdata SHALL be driven from the latched values, and mem_we SHALL equal the latched we for exactly that one cycle.
REQ-026 mem_we SHALL be 0 in every state other than ACCESS.
REQ-027 In RESP, mem_rdata SHALL be registered into the granted requester's rdata for reads; for writes, rdata SHALL be left unchanged.
REQ-028 The granted requester's ack SHALL be a registered pulse, high for exactly the one cycle after RESP, when the FSM is back in IDLE.
REQ-029 The other requester's ack and rdata SHALL NOT change during the access.
REQ-030 Latency: req first high in cycle N with the FSM in IDLE gives ACCESS in N+1, RESP in N+2, and ack in N+3.
REQ-031 Back-to-back: the cycle carrying ack is an IDLE cycle, and the other requester's pending req SHALL be granted at its end (ACCESS in N+4); sustained throughput is one access per 3 cycles.
REQ-032 If req is dropped after grant, the access SHALL still complete and ack SHALL still pulse; there is no abort.
REQ-033 owner SHALL update on the grant edge and hold its value through IDLE.
REQ-034 Address and data SHALL pass through unmodified; there is no arithmetic or address wrap logic, and any ADDR_W-bit value is legal.

Reset
REQ-035 With reset_n=0 at a clock edge, regardless of state (including mid-access), the block SHALL go to: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, p_ack=0, l_ack=0, p_rdata=0, l_rdata=0, busy=0, owner=1.
REQ-036 An access interrupted by reset SHALL NOT produce an ack.
REQ-037 The first arbitration after reset SHALL favour the processor when both requesters are eligible.
REQ-038 Requests SHALL be ignored while reset_n=0; arbitration resumes at the first edge with reset_n=1.

Verification
REQ-039 Processor write p_addr=0x0010, p_wdata=0xBEEF -> mem_we=1 with mem_addr=0x0010 for exactly one cycle, and p_ack pulses 3 cycles after req.
REQ-040 Processor read of 0x0010 after that write -> p_rdata=0xBEEF while p_ack=1; l_ack stays 0 throughout.
REQ-041 p_req and l_req raised in the same cycle after reset -> processor is served first, then the loader with ACCESS one cycle after p_ack; owner sequence is 0 then 1.
REQ-042 Both requesters held high continuously -> grants alternate P,L,P,L, with an ack every 3 cycles.
REQ-043 Assert reset_n=0 during ACCESS of a loader write -> no l_ack, mem_we=0 on the next cycle, and all outputs at reset values.
REQ-044 Change p_addr from 0x0001 to 0x0002 one cycle after grant -> mem_addr=0x0001 during ACCESS.
